// File: rtl/chip_cp_pkg.sv
// Shared control-plane types for the chip-level splitter and its neighbours.
package chip_cp_pkg;

   localparam int CP_ADDR_WIDTH = 37;
   localparam int CP_DATA_WIDTH = 28;

   typedef enum logic [1:0] {IDLE, FWD, WAIT_RSP, RESP} cp_split_state_t;
   typedef enum logic {TGT_A, TGT_B} cp_target_t;

   typedef struct packed {
      logic [CP_ADDR_WIDTH-1:0] addr;
      logic [CP_DATA_WIDTH-1:0] data;
      logic                     we;
   } cp_req_t;

   typedef struct packed {
      logic [CP_DATA_WIDTH-1:0] data;
      logic                     err;
   } cp_rsp_t;

endpackage

// File: rtl/chip_sat_counter.sv
// Saturating up-counter with a multi-unit increment and a synchronous clear.
module chip_sat_counter #(
   parameter int WIDTH = 8,
   parameter int INC_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic [INC_W-1:0] inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam int SW = WIDTH + 1;

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   sum;

   // One spare bit catches the carry, which pins the count at all-ones.
   always_comb begin
      sum   = {1'b0, cnt_q} + SW'(inc_i);
      cnt_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) cnt_q <= '0;
      else                   cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/chip_cp_splitter.sv
// Routes host control-plane requests to block_a/block_b, one outstanding, with response timeout.
// Optional statistics counters are built when CHIP_CP_SPLITTER_STATS_EN is defined.
module chip_cp_splitter
   import chip_cp_pkg::*;
#(
   parameter int ADDR_WIDTH     = CP_ADDR_WIDTH,
   parameter int DATA_WIDTH     = CP_DATA_WIDTH,
   parameter int SEL_BIT        = 36,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  host_req_valid,
   output logic                  host_req_ready,
   input  logic [ADDR_WIDTH-1:0] host_req_addr,
   input  logic [DATA_WIDTH-1:0] host_req_data,
   input  logic                  host_req_we,
   output logic                  a_req_valid,
   input  logic                  a_req_ready,
   output logic [ADDR_WIDTH-1:0] a_req_addr,
   output logic [DATA_WIDTH-1:0] a_req_data,
   output logic                  a_req_we,
   output logic                  b_req_valid,
   input  logic                  b_req_ready,
   output logic [ADDR_WIDTH-1:0] b_req_addr,
   output logic [DATA_WIDTH-1:0] b_req_data,
   output logic                  b_req_we,
   input  logic                  a_rsp_valid,
   input  logic [DATA_WIDTH-1:0] a_rsp_data,
   input  logic                  b_rsp_valid,
   input  logic [DATA_WIDTH-1:0] b_rsp_data,
   output logic                  host_rsp_valid,
   input  logic                  host_rsp_ready,
   output logic [DATA_WIDTH-1:0] host_rsp_data,
   output logic                  host_rsp_err,
   output logic [7:0]            drop_cnt,
   output logic [15:0]           req_cnt_a,
   output logic [15:0]           req_cnt_b,
   output logic [15:0]           timeout_cnt
);

   localparam logic [ADDR_WIDTH-1:0] SEL_MASK   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << SEL_BIT;
   localparam logic [15:0]           TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   cp_split_state_t       state_q;
   cp_target_t            tgt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  we_q;
   logic                  a_vld_q, b_vld_q, rsp_vld_q, rsp_err_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic [15:0]           timer_q;

   logic                  in_wait, sel_rsp_vld, fwd_hs, timeout, a_drop, b_drop;
   logic [DATA_WIDTH-1:0] sel_rsp_data;
   logic [1:0]            drop_inc;

   assign in_wait      = (state_q == WAIT_RSP);
   assign sel_rsp_vld  = (tgt_q == TGT_B) ? b_rsp_valid : a_rsp_valid;
   assign sel_rsp_data = (tgt_q == TGT_B) ? b_rsp_data  : a_rsp_data;
   assign fwd_hs       = (a_vld_q & a_req_ready) | (b_vld_q & b_req_ready);
   assign timeout      = in_wait & ~sel_rsp_vld & (timer_q == TIMER_LAST);

   // Only the selected target's response while waiting is consumed; everything else is dropped.
   assign a_drop   = a_rsp_valid & ~(in_wait & (tgt_q == TGT_A));
   assign b_drop   = b_rsp_valid & ~(in_wait & (tgt_q == TGT_B));
   assign drop_inc = {1'b0, a_drop} + {1'b0, b_drop};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tgt_q      <= TGT_A;
         addr_q     <= '0;
         data_q     <= '0;
         we_q       <= 1'b0;
         a_vld_q    <= 1'b0;
         b_vld_q    <= 1'b0;
         rsp_vld_q  <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         timer_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (host_req_valid) begin
               addr_q  <= host_req_addr & ~SEL_MASK;
               data_q  <= host_req_data;
               we_q    <= host_req_we;
               tgt_q   <= host_req_addr[SEL_BIT] ? TGT_B : TGT_A;
               a_vld_q <= ~host_req_addr[SEL_BIT];
               b_vld_q <= host_req_addr[SEL_BIT];
               state_q <= FWD;
            end
            FWD: if (fwd_hs) begin
               a_vld_q <= 1'b0;
               b_vld_q <= 1'b0;
               timer_q <= '0;
               state_q <= WAIT_RSP;
            end
            WAIT_RSP: begin
               // A response in the timeout cycle takes priority over the error.
               if (sel_rsp_vld) begin
                  rsp_data_q <= sel_rsp_data;
                  rsp_err_q  <= 1'b0;
                  rsp_vld_q  <= 1'b1;
                  state_q    <= RESP;
               end else if (timeout) begin
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
                  rsp_vld_q  <= 1'b1;
                  state_q    <= RESP;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            RESP: if (host_rsp_ready) begin
               rsp_vld_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign host_req_ready = (state_q == IDLE) & rst_n;
   assign a_req_valid    = a_vld_q;
   assign b_req_valid    = b_vld_q;
   assign a_req_addr     = addr_q;
   assign b_req_addr     = addr_q;
   assign a_req_data     = data_q;
   assign b_req_data     = data_q;
   assign a_req_we       = we_q;
   assign b_req_we       = we_q;
   assign host_rsp_valid = rsp_vld_q;
   assign host_rsp_data  = rsp_data_q;
   assign host_rsp_err   = rsp_err_q;

   chip_sat_counter #(.WIDTH(8), .INC_W(2)) u_drop_cnt (
      .clk(clk), .rst_n(rst_n), .clear_i(1'b0), .inc_i(drop_inc), .cnt_o(drop_cnt)
   );

`ifdef CHIP_CP_SPLITTER_STATS_EN
   chip_sat_counter #(.WIDTH(16), .INC_W(1)) u_req_cnt_a (
      .clk(clk), .rst_n(rst_n), .clear_i(1'b0), .inc_i(a_vld_q & a_req_ready), .cnt_o(req_cnt_a)
   );
   chip_sat_counter #(.WIDTH(16), .INC_W(1)) u_req_cnt_b (
      .clk(clk), .rst_n(rst_n), .clear_i(1'b0), .inc_i(b_vld_q & b_req_ready), .cnt_o(req_cnt_b)
   );
   chip_sat_counter #(.WIDTH(16), .INC_W(1)) u_timeout_cnt (
      .clk(clk), .rst_n(rst_n), .clear_i(1'b0), .inc_i(timeout), .cnt_o(timeout_cnt)
   );
`else
   assign req_cnt_a   = '0;
   assign req_cnt_b   = '0;
   assign timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_chip_cp_splitter.sv
// Randomized transaction-level bench for chip_cp_splitter (TIMEOUT_CYCLES=8).
module tb_chip_cp_splitter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        host_req_valid, host_req_ready, host_req_we;
   logic [36:0] host_req_addr;
   logic [27:0] host_req_data;
   logic        a_req_valid, a_req_ready, a_req_we;
   logic [36:0] a_req_addr;
   logic [27:0] a_req_data;
   logic        b_req_valid, b_req_ready, b_req_we;
   logic [36:0] b_req_addr;
   logic [27:0] b_req_data;
   logic        a_rsp_valid, b_rsp_valid;
   logic [27:0] a_rsp_data, b_rsp_data;
   logic        host_rsp_valid, host_rsp_ready, host_rsp_err;
   logic [27:0] host_rsp_data;
   logic [7:0]  drop_cnt;
   logic [15:0] req_cnt_a, req_cnt_b, timeout_cnt;

   int nvec = 0, nerr = 0;
   int exp_drop = 0, n_a = 0, n_b = 0, n_to = 0;

   chip_cp_splitter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
      .host_req_addr(host_req_addr), .host_req_data(host_req_data), .host_req_we(host_req_we),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
      .a_req_data(a_req_data), .a_req_we(a_req_we),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
      .b_req_data(b_req_data), .b_req_we(b_req_we),
      .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
      .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
      .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
      .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
      .drop_cnt(drop_cnt), .req_cnt_a(req_cnt_a), .req_cnt_b(req_cnt_b), .timeout_cnt(timeout_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void add_drop(input int n);
      exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
   endfunction

   task automatic chk_counters();
      chk("drop_cnt", drop_cnt, exp_drop);
`ifdef CHIP_CP_SPLITTER_STATS_EN
      chk("req_cnt_a", req_cnt_a, n_a);
      chk("req_cnt_b", req_cnt_b, n_b);
      chk("timeout_cnt", timeout_cnt, n_to);
`else
      chk("stats_tied", {req_cnt_a, req_cnt_b, timeout_cnt}, 0);
`endif
   endtask

   // rsp_dly >= TO means the target never answers.
   task automatic run_txn(input bit tgt, input logic [35:0] lo, input logic [27:0] wd,
                          input bit we, input int rdy_dly, input int rsp_dly,
                          input logic [27:0] rd, input int hr_dly, input bit inj, input bit late);
      bit          timed_out;
      logic [27:0] exp_data;
      timed_out = (rsp_dly >= TO);
      exp_data  = timed_out ? 28'd0 : rd;
      chk("idle_req_ready", host_req_ready, 1);
      host_req_valid = 1'b1;
      host_req_addr  = {tgt, lo};
      host_req_data  = wd;
      host_req_we    = we;
      tick();
      host_req_valid = 1'b0;
      host_req_addr  = 37'({$urandom(), $urandom()});
      host_req_data  = 28'($urandom());
      host_req_we    = 1'($urandom());
      for (int i = 0; i <= rdy_dly; i++) begin
         chk("fwd_req_ready", host_req_ready, 0);
         chk("fwd_valids", {a_req_valid, b_req_valid}, {!tgt, tgt});
         chk("fwd_addr", tgt ? b_req_addr : a_req_addr, {1'b0, lo});
         chk("fwd_data", tgt ? b_req_data : a_req_data, wd);
         chk("fwd_we", tgt ? b_req_we : a_req_we, we);
         if (i == rdy_dly) begin
            if (tgt) b_req_ready = 1'b1;
            else     a_req_ready = 1'b1;
         end
         tick();
      end
      a_req_ready = 1'b0;
      b_req_ready = 1'b0;
      if (tgt) n_b++;
      else     n_a++;
      for (int i = 0; i < TO; i++) begin
         chk("wait_rsp_valid", host_rsp_valid, 0);
         chk("wait_req_valids", {a_req_valid, b_req_valid}, 0);
         if (inj && i == 0) begin
            if (tgt) begin a_rsp_valid = 1'b1; a_rsp_data = 28'($urandom()); end
            else     begin b_rsp_valid = 1'b1; b_rsp_data = 28'($urandom()); end
            add_drop(1);
         end
         if (i == rsp_dly) begin
            if (tgt) begin b_rsp_valid = 1'b1; b_rsp_data = rd; end
            else     begin a_rsp_valid = 1'b1; a_rsp_data = rd; end
         end
         tick();
         a_rsp_valid = 1'b0;
         b_rsp_valid = 1'b0;
         if (i == rsp_dly) break;
      end
      if (timed_out) n_to++;
      for (int i = 0; i <= hr_dly; i++) begin
         chk("rsp_valid", host_rsp_valid, 1);
         chk("rsp_data", host_rsp_data, exp_data);
         chk("rsp_err", host_rsp_err, timed_out);
         chk("rsp_req_ready", host_req_ready, 0);
         chk("rsp_req_valids", {a_req_valid, b_req_valid}, 0);
         if (i == hr_dly) host_rsp_ready = 1'b1;
         tick();
      end
      host_rsp_ready = 1'b0;
      chk("post_rsp_valid", host_rsp_valid, 0);
      chk("post_req_ready", host_req_ready, 1);
      if (timed_out && late) begin
         if (tgt) b_rsp_valid = 1'b1;
         else     a_rsp_valid = 1'b1;
         add_drop(1);
         tick();
         a_rsp_valid = 1'b0;
         b_rsp_valid = 1'b0;
      end
      chk_counters();
   endtask

   initial begin
      rst_n = 1'b0;
      host_req_valid = 1'b0; host_req_addr = '0; host_req_data = '0; host_req_we = 1'b0;
      a_req_ready = 1'b0; b_req_ready = 1'b0; host_rsp_ready = 1'b0;
      a_rsp_valid = 1'b0; b_rsp_valid = 1'b0; a_rsp_data = '0; b_rsp_data = '0;
      tick();
      tick();
      chk("rst_valids", {a_req_valid, b_req_valid, host_rsp_valid}, 0);
      chk("rst_req_ready", host_req_ready, 0);
      chk("rst_payload", {a_req_addr, a_req_data, a_req_we}, 0);
      chk("rst_rsp", {host_rsp_data, host_rsp_err}, 0);
      chk_counters();
      rst_n = 1'b1;
      tick();

      run_txn(1'b0, 36'h0_0000_0010, 28'h0, 1'b0, 0, 2, 28'h0ABCDEF, 0, 1'b0, 1'b0);
      run_txn(1'b1, 36'h0_0000_0020, 28'h1234567, 1'b1, 5, 0, 28'h0, 0, 1'b0, 1'b0);
      run_txn(1'b0, 36'h0_0000_0040, 28'h0, 1'b0, 0, TO, 28'h5A5A5A5, 0, 1'b0, 1'b1);
      chk("timeout_late_drop", drop_cnt, 1);
      run_txn(1'b1, 36'h0_0000_0080, 28'h0, 1'b0, 1, TO - 1, 28'h7654321, 4, 1'b0, 1'b0);
      run_txn(1'b0, 36'hF_FFFF_FFFF, 28'hFFFFFFF, 1'b1, 0, 0, 28'hFFFFFFF, 0, 1'b1, 1'b0);

      for (int n = 0; n < 40; n++)
         run_txn(1'($urandom()), 36'({$urandom(), $urandom()}), 28'($urandom()), 1'($urandom()),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, TO)), 28'($urandom()),
                 int'($urandom_range(0, 3)), 1'($urandom()), 1'($urandom()));

      // Simultaneous spurious responses in IDLE until the drop counter pins.
      for (int n = 0; n < 130; n++) begin
         a_rsp_valid = 1'b1;
         b_rsp_valid = 1'b1;
         add_drop(2);
         tick();
         if (n == 0) chk("double_drop", drop_cnt, exp_drop);
      end
      a_rsp_valid = 1'b0;
      b_rsp_valid = 1'b0;
      chk("drop_saturated", drop_cnt, 255);

      // Reset while waiting for block_a.
      host_req_valid = 1'b1;
      host_req_addr  = 37'h0_0000_0100;
      tick();
      host_req_valid = 1'b0;
      a_req_ready = 1'b1;
      tick();
      a_req_ready = 1'b0;
      chk("pre_rst_wait", {a_req_valid, host_req_ready, host_rsp_valid}, 0);
      rst_n = 1'b0;
      tick();
      chk("midrst_valids", {a_req_valid, b_req_valid, host_rsp_valid, host_req_ready}, 0);
      exp_drop = 0; n_a = 0; n_b = 0; n_to = 0;
      rst_n = 1'b1;
      #1;
      chk("midrst_idle_ready", host_req_ready, 1);
      a_rsp_valid = 1'b1;
      add_drop(1);
      tick();
      a_rsp_valid = 1'b0;
      chk("post_rst_drop", drop_cnt, 1);
      run_txn(1'b0, 36'h0_0000_0200, 28'h0000123, 1'b1, 1, 3, 28'h0C0FFEE, 1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/chip_cp_splitter.md
Name: chip_cp_splitter

Overview:
- Upstream neighbour of the block_a and block_b control_plane_in ports.
- Accepts one host control-plane request stream and routes each request to block_a or block_b by an address select bit.
- Waits for that block's response, with a timeout, and returns exactly one in-order response per request to the host.
- Single outstanding transaction; unexpected target responses are dropped and counted.

Parameters:
- ADDR_WIDTH, 37, control-plane address width.
- DATA_WIDTH, 28, control-plane data width.
- SEL_BIT, 36, address bit selecting the target: 0 = block_a, 1 = block_b.
- TIMEOUT_CYCLES, 255, maximum WAIT_RSP cycles before an error response. Legal range 1..65535.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- host_req_valid / host_req_ready  in / out  1 / 1  host request handshake.
- host_req_addr / host_req_data / host_req_we  in  ADDR_WIDTH / DATA_WIDTH / 1  host request payload.
- a_req_valid / a_req_ready  out / in  1 / 1  block_a request handshake.
- a_req_addr / a_req_data / a_req_we  out  ADDR_WIDTH / DATA_WIDTH / 1  block_a request payload.
- b_req_valid, b_req_ready, b_req_addr, b_req_data, b_req_we  same directions and widths as the block_a set, toward block_b.
- a_rsp_valid / a_rsp_data  in  1 / DATA_WIDTH  block_a response; no backpressure.
- b_rsp_valid / b_rsp_data  in  1 / DATA_WIDTH  block_b response; no backpressure.
- host_rsp_valid / host_rsp_ready  out / in  1 / 1  host response handshake.
- host_rsp_data / host_rsp_err  out  DATA_WIDTH / 1  response payload; err = timeout.
- drop_cnt  out  8  saturating count of dropped target responses.

Behaviour:
- Clock and reset: one clock clk. rst_n is synchronous and active-low.
- Reset values:
  - state=IDLE.
  - All *_valid outputs 0.
  - host_req_ready 0 during reset.
  - Payload registers 0; host_rsp_data 0; host_rsp_err 0.
  - drop_cnt 0; timer 0.
- IDLE:
  - host_req_ready=1.
  - On host_req_valid & host_req_ready, latch addr/data/we and the target (addr[SEL_BIT]), then go to FWD.
- FWD:
  - host_req_ready=0. Drive the selected x_req_valid=1 from registers; the other target's valid stays 0.
  - Forwarded addr = latched addr with bit SEL_BIT cleared; data and we unchanged.
  - Payload is held stable until x_req_ready. On x_req_valid & x_req_ready, go to WAIT_RSP with timer=0.
  - No timeout in FWD; it may stall indefinitely.
- WAIT_RSP:
  - Timer increments every cycle.
  - Selected x_rsp_valid: capture data, err=0, go to RESP.
  - Otherwise, when timer == TIMEOUT_CYCLES-1: data=0, err=1, go to RESP.
  - If a response and the timeout occur in the same cycle, the response wins.
- RESP:
  - host_rsp_valid=1; data/err held stable until host_rsp_ready, then go to IDLE.
  - host_req_ready stays 0 in RESP; the next request is accepted no earlier than the first IDLE cycle.
- Latency:
  - Host accept at cycle t gives x_req_valid at t+1.
  - Target response at cycle r gives host_rsp_valid at r+1.
  - Best-case round trip: accept t, target ready t+1, response t+2, host_rsp_valid t+3.
- Drops: any a_rsp_valid or b_rsp_valid not consumed by WAIT_RSP (wrong state, or non-selected target) increments drop_cnt.
  - Two drops in one cycle add 2.
  - drop_cnt saturates at 255, never wraps.
- A late response after a timeout is a drop.
- Reset mid-operation: the FSM returns to IDLE and all valids fall in the same cycle. A response arriving after reset release is a drop.
- Writes also get a response: target response data is passed through unchanged.

Optional Feature:
- Macro: CHIP_CP_SPLITTER_STATS_EN.
- When defined, adds outputs req_cnt_a[15:0], req_cnt_b[15:0] and timeout_cnt[15:0].
  - req_cnt_a / req_cnt_b increment on each forwarded handshake to that target.
  - timeout_cnt increments on each timeout.
  - All saturate at 65535 and reset to 0.
- When undefined, these ports still exist but are tied to 0 and no counter logic is built.

Decomposition:
- Package chip_cp_pkg:
  - CP_ADDR_WIDTH=37, CP_DATA_WIDTH=28.
  - typedef enum {IDLE, FWD, WAIT_RSP, RESP} cp_split_state_t.
  - typedef enum logic {TGT_A, TGT_B} cp_target_t.
  - Request and response struct typedefs.
- Sub-module chip_sat_counter: parameter WIDTH, inputs inc amount and clear, saturating. Used for drop_cnt and for the stats counters.

Test Plan:
- Read to block_a: host addr=0x0_0000_0010, we=0; a_req_ready=1 next cycle; a_rsp data=0xABCDEF after 3 cycles -> a_req_addr=0x10, host_rsp_data=0xABCDEF, err=0, b_req_valid never 1.
- Write to block_b: addr=0x10_0000_0020, data=0x1234567, we=1 -> b_req_addr=0x20, data/we intact; b_req_ready held 0 for 5 cycles with payload stable; b_rsp data=0 -> host_rsp_valid the cycle after.
- Timeout: TIMEOUT_CYCLES=8, no response -> host_rsp_err=1, data=0, 8 cycles after the forward handshake; a response arriving later -> drop_cnt=1.
- Spurious and simultaneous responses: a_rsp_valid and b_rsp_valid both asserted in IDLE -> drop_cnt +2. Force 130 such cycles -> drop_cnt saturates at 255.
- Host backpressure: host_rsp_ready=0 for 4 cycles -> rsp data/err stable, host_req_ready=0, no new forwarding. Release -> host_req_ready=1 the next cycle.
- Reset in WAIT_RSP: rst_n=0 for 1 cycle -> all valids 0 and state IDLE. A subsequent a_rsp_valid -> drop_cnt=1; a new request completes normally.
